// File: rtl/mu0_bus_pkg.sv
// Shared constants and types for the MU0 bus responder and its output FIFO.
package mu0_bus_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 12;

    localparam logic [ADDR_W-1:0] ADDR_TX_DATA = 12'hFF0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 12'hFF1;
    localparam logic [ADDR_W-1:0] ADDR_TICK    = 12'hFF2;
    localparam logic [ADDR_W-1:0] ADDR_LED     = 12'hFF3;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_ERR   = 3;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_t;

endpackage

// File: rtl/mu0_out_fifo.sv
// Output-stream FIFO; occupancy FSM (EMPTY/PARTIAL/FULL) follows the entry counter.
module mu0_out_fifo
    import mu0_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg, count_next;
    fifo_state_t       state_reg, state_next;
    logic              push_ok, pop_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= FIFO_EMPTY;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end

    // A pop frees the slot that a same-cycle push into a full FIFO reuses.
    always_comb begin
        pop_ok     = pop && (state_reg != FIFO_EMPTY);
        push_ok    = push && ((state_reg != FIFO_FULL) || pop_ok);
        overflow   = push && (state_reg == FIFO_FULL) && !pop_ok;
        count_next = count_reg;
        if (push_ok && !pop_ok)
            count_next = count_reg + CW'(1);
        else if (pop_ok && !push_ok)
            count_next = count_reg - CW'(1);
        state_next = FIFO_PARTIAL;
        if (count_next == '0)
            state_next = FIFO_EMPTY;
        else if (count_next == FULL_COUNT)
            state_next = FIFO_FULL;
    end

    assign empty = (state_reg == FIFO_EMPTY);
    assign full  = (state_reg == FIFO_FULL);
    assign head  = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/mu0_bus_responder.sv
// MU0 memory-side responder: RAM, I/O page (TX FIFO, STATUS, TICK, LED), combinational reads.
// Define MU0_BUS_ERR_EN to add the bus_err port and the STATUS error sticky bit.
module mu0_bus_responder
    import mu0_bus_pkg::*;
#(
    parameter int    RAM_WORDS  = 3072,
    parameter int    FIFO_DEPTH = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] data_out,
    input  logic              memory_read,
    input  logic              memory_write,
    output logic [WORD_W-1:0] data_in,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    input  logic              out_ready,
    output logic [WORD_W-1:0] leds
`ifdef MU0_BUS_ERR_EN
    ,
    output logic              bus_err
`endif
);

    localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W+1)'(RAM_WORDS);

    logic [WORD_W-1:0] ram [RAM_WORDS];
    logic [WORD_W-1:0] tick_reg, led_reg, status_word;
    logic              ovf_sticky_reg, err_sticky;
    logic              in_ram, sel_tx, sel_status, sel_tick, sel_led;
    logic              fifo_empty, fifo_full, fifo_overflow;

    assign in_ram     = ({1'b0, address} < RAM_LIMIT);
    assign sel_tx     = (address == ADDR_TX_DATA);
    assign sel_status = (address == ADDR_STATUS);
    assign sel_tick   = (address == ADDR_TICK);
    assign sel_led    = (address == ADDR_LED);

    always_ff @(posedge clk) begin
        if (memory_write && in_ram) ram[address] <= data_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_reg       <= '0;
            led_reg        <= '0;
            ovf_sticky_reg <= 1'b0;
        end else begin
            tick_reg <= (memory_write && sel_tick) ? data_out : tick_reg + WORD_W'(1);
            if (memory_write && sel_led) led_reg <= data_out;
            // Setting the sticky bit takes priority over a STATUS write clearing it.
            if (fifo_overflow)
                ovf_sticky_reg <= 1'b1;
            else if (memory_write && sel_status)
                ovf_sticky_reg <= 1'b0;
        end
    end

`ifdef MU0_BUS_ERR_EN
    logic access_err, err_sticky_reg, bus_err_reg;

    assign access_err = (memory_read || memory_write) &&
                        !(in_ram || sel_tx || sel_status || sel_tick || sel_led);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky_reg <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            bus_err_reg <= access_err;
            if (access_err)
                err_sticky_reg <= 1'b1;
            else if (memory_write && sel_status)
                err_sticky_reg <= 1'b0;
        end
    end

    assign err_sticky = err_sticky_reg;
    assign bus_err    = bus_err_reg;
`else
    assign err_sticky = 1'b0;
`endif

    mu0_out_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (memory_write && sel_tx),
        .push_data(data_out),
        .pop      (out_ready),
        .head     (out_data),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (fifo_overflow)
    );

    always_comb begin
        status_word             = '0;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_OVF]   = ovf_sticky_reg;
        status_word[STAT_ERR]   = err_sticky;
    end

    // Pre-write values are returned when a read and write coincide.
    always_comb begin
        data_in = '0;
        if (memory_read) begin
            if (in_ram)
                data_in = ram[address];
            else if (sel_status)
                data_in = status_word;
            else if (sel_tick)
                data_in = tick_reg;
            else if (sel_led)
                data_in = led_reg;
        end
    end

    assign out_valid = !fifo_empty;
    assign leds      = led_reg;

endmodule

// File: tb/tb_mu0_bus_responder.sv
// Directed bench for mu0_bus_responder: behavioural model with per-cycle compare plus literal checks.
module tb_mu0_bus_responder;

    localparam int RAM_WORDS = 3072;
    localparam int DEPTH     = 4;
`ifdef MU0_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] address = '0;
    logic [15:0] data_out = '0;
    logic        memory_read = 1'b0;
    logic        memory_write = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] data_in, out_data, leds;
    logic        out_valid;
    logic        bus_err_obs;

    int checks = 0;
    int passes = 0;

    mu0_bus_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(DEPTH),
        .INIT_FILE ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .data_out    (data_out),
        .memory_read (memory_read),
        .memory_write(memory_write),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .leds        (leds)
`ifdef MU0_BUS_ERR_EN
        ,
        .bus_err     (bus_err_obs)
`endif
    );

`ifndef MU0_BUS_ERR_EN
    assign bus_err_obs = 1'b0;
`endif

    initial forever #5 clk = ~clk;

    // Behavioural model state
    logic [15:0] m_ram [int];
    logic [15:0] m_q[$];
    logic [15:0] m_tick = '0;
    logic [15:0] m_leds = '0;
    bit          m_ovf = 1'b0;
    bit          m_err = 1'b0;
    bit          m_buserr = 1'b0;
    bit          m_pop, m_unmapped;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit is_unmapped(input logic [11:0] a);
        return (int'(a) >= RAM_WORDS) && (a < 12'hFF0 || a > 12'hFF3);
    endfunction

    function automatic logic [15:0] m_status();
        logic [15:0] s = '0;
        s[0] = (m_q.size() == 0);
        s[1] = (m_q.size() == DEPTH);
        s[2] = m_ovf;
        s[3] = m_err;
        return s;
    endfunction

    function automatic logic [15:0] m_rdata();
        if (!memory_read) return 16'h0000;
        if (int'(address) < RAM_WORDS) return m_ram.exists(int'(address)) ? m_ram[int'(address)] : 16'hxxxx;
        case (address)
            12'hFF1: return m_status();
            12'hFF2: return m_tick;
            12'hFF3: return m_leds;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_tick   = '0;
            m_leds   = '0;
            m_ovf    = 1'b0;
            m_err    = 1'b0;
            m_buserr = 1'b0;
        end else begin
            m_pop      = out_ready && (m_q.size() > 0);
            m_unmapped = ERR_EN && (memory_read || memory_write) && is_unmapped(address);
            m_buserr   = m_unmapped;
            if (memory_write && address == 12'hFF1) begin
                m_ovf = 1'b0;
                m_err = 1'b0;
            end
            if (m_unmapped) m_err = 1'b1;
            if (m_pop) void'(m_q.pop_front());
            if (memory_write && address == 12'hFF0) begin
                if (m_q.size() < DEPTH) m_q.push_back(data_out);
                else m_ovf = 1'b1;
            end
            if (memory_write && int'(address) < RAM_WORDS) m_ram[int'(address)] = data_out;
            m_tick = (memory_write && address == 12'hFF2) ? data_out : m_tick + 16'd1;
            if (memory_write && address == 12'hFF3) m_leds = data_out;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [15:0] exp_d;
        exp_d = m_rdata();
        if (!$isunknown(exp_d)) chk("data_in", data_in, exp_d);
        chk("out_valid", {15'b0, out_valid}, {15'b0, m_q.size() > 0});
        if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
        chk("leds", leds, m_leds);
        if (ERR_EN) chk("bus_err", {15'b0, bus_err_obs}, {15'b0, m_buserr});
    end

    task automatic step(input logic [11:0] a, input logic [15:0] d, input logic rd,
                        input logic wr, input logic rdy);
        @(posedge clk);
        #2;
        address = a; data_out = d; memory_read = rd; memory_write = wr; out_ready = rdy;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", {15'b0, out_valid}, 16'h0000);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_leds", leds, 16'h0000);
        @(posedge clk);
        #2 rst = 1'b1;

        // RAM write / readback
        step(12'h005, 16'h1234, 0, 1, 0);
        step(12'h005, 16'h0000, 1, 0, 0);
        chk("ram_readback", data_in, 16'h1234);
        step(12'h005, 16'h0000, 0, 0, 0);
        chk("read_disabled", data_in, 16'h0000);

        // TICK load and wrap
        step(12'hFF2, 16'hFFFE, 0, 1, 0);
        step(12'hFF2, 16'h0000, 1, 0, 0);
        chk("tick0", data_in, 16'hFFFE);
        step(12'hFF2, 16'h0000, 1, 0, 0);
        chk("tick1", data_in, 16'hFFFF);
        step(12'hFF2, 16'h0000, 1, 0, 0);
        chk("tick2", data_in, 16'h0000);

        // Fill past depth, then drain
        for (int i = 0; i < 5; i++) step(12'hFF0, 16'h00A1 + 16'(i), 0, 1, 0);
        step(12'hFF0, 16'h0000, 1, 0, 0);
        chk("tx_read_zero", data_in, 16'h0000);
        step(12'hFF1, 16'h0000, 1, 0, 0);
        chk("status_full_ovf", data_in, 16'h0006);
        for (int i = 0; i < 4; i++) begin
            step(12'h000, 16'h0000, 0, 0, 1);
            chk("pop_order", out_data, 16'h00A1 + 16'(i));
        end
        step(12'hFF1, 16'h0000, 1, 0, 1);
        chk("drained_valid", {15'b0, out_valid}, 16'h0000);
        chk("status_empty_ovf", data_in, 16'h0005);
        step(12'hFF1, 16'h0000, 0, 1, 0);
        step(12'hFF1, 16'h0000, 1, 0, 0);
        chk("status_cleared", data_in, 16'h0001);

        // Push into a full FIFO while popping
        for (int i = 0; i < 4; i++) step(12'hFF0, 16'h00C1 + 16'(i), 0, 1, 0);
        step(12'hFF0, 16'h00B0, 0, 1, 1);
        chk("head_c1", out_data, 16'h00C1);
        step(12'hFF1, 16'h0000, 1, 0, 1);
        chk("status_full_no_ovf", data_in, 16'h0002);
        chk("head_c2", out_data, 16'h00C2);
        step(12'h000, 16'h0000, 0, 0, 1);
        chk("head_c3", out_data, 16'h00C3);
        step(12'h000, 16'h0000, 0, 0, 1);
        chk("head_c4", out_data, 16'h00C4);
        step(12'h000, 16'h0000, 0, 0, 1);
        chk("head_b0", out_data, 16'h00B0);
        step(12'hFF1, 16'h0000, 1, 0, 1);
        chk("status_after_b0", data_in, 16'h0001);

        // Asynchronous reset mid-stream
        step(12'hFF3, 16'h5A5A, 0, 1, 0);
        step(12'hFF3, 16'h0000, 1, 0, 0);
        chk("led_set", leds, 16'h5A5A);
        step(12'hFF0, 16'h00D1, 0, 1, 0);
        step(12'hFF0, 16'h00D2, 0, 1, 0);
        chk("queued_valid", {15'b0, out_valid}, 16'h0001);
        @(posedge clk);
        #2;
        memory_write = 1'b0; memory_read = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_async_valid", {15'b0, out_valid}, 16'h0000);
        chk("rst_async_data", out_data, 16'h0000);
        chk("rst_async_leds", leds, 16'h0000);
        @(posedge clk);
        #2 rst = 1'b1;
        step(12'hFF1, 16'h0000, 1, 0, 0);
        chk("status_after_rst", data_in, 16'h0001);
        chk("leds_after_rst", leds, 16'h0000);
        step(12'h005, 16'h0000, 1, 0, 0);
        chk("ram_retained", data_in, 16'h1234);

        // Read and write in the same cycle
        step(12'h005, 16'h9999, 1, 1, 0);
        chk("rw_prewrite", data_in, 16'h1234);
        step(12'h005, 16'h0000, 1, 0, 0);
        chk("rw_newvalue", data_in, 16'h9999);

        // Unmapped access
        step(12'hFF8, 16'h0000, 1, 0, 0);
        chk("unmapped_read", data_in, 16'h0000);
        step(12'h000, 16'h0000, 0, 0, 0);
        if (ERR_EN) chk("bus_err_pulse", {15'b0, bus_err_obs}, 16'h0001);
        step(12'hFF1, 16'h0000, 1, 0, 0);
        if (ERR_EN) begin
            chk("bus_err_drop", {15'b0, bus_err_obs}, 16'h0000);
            chk("status_err", data_in, 16'h0009);
        end else begin
            chk("status_no_err", data_in, 16'h0001);
        end
        step(12'hFF9, 16'h1111, 0, 1, 0);
        step(12'hFFA, 16'h0000, 1, 0, 0);
        step(12'h000, 16'h0000, 0, 0, 0);
        step(12'h000, 16'h0000, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
